turfio_ddr_writer: RTL

// - AXI4 write master feeding one slave port of the DDR interconnect (the t0..t3 event-data ports).
// - Takes a write command (base address and beat count) plus an AXI4-Stream of event data from one TURFIO path.
// - Splits the transfer into INCR bursts that never cross a 4 KB boundary and tracks write responses.
// - Reports completion and error status per command.

---
 rtl/turfio_ddr_writer_pkg.sv | 9 +
 rtl/turfio_ddr_writer_burst_len.sv | 20 ++
 rtl/turfio_ddr_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/turfio_ddr_writer_pkg.sv
// turfio_ddr_writer_pkg: FSM encoding and fixed AXI constants shared by the DDR writer.
package turfio_ddr_writer_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_AWREQ, ST_WDATA, ST_WAITB} state_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
    localparam int         BOUNDARY_4K    = 4096;
endpackage

// File: rtl/turfio_ddr_writer_burst_len.sv
// ddr_burst_len: beats in the next burst = min(remaining, MAX_BURST, beats left before the 4 KB page end).
module ddr_burst_len
    import turfio_ddr_writer_pkg::*;
#(
    parameter int BYTES     = 64,
    parameter int MAX_BURST = 64
) (
    input  logic [15:0] rem_i,
    input  logic [11:0] addr_lo_i,
    output logic [7:0]  blen_o
);
    localparam int BSHIFT = $clog2(BYTES);
    logic [12:0] room;
    logic [15:0] cap;
    always_comb begin
        room   = (13'(BOUNDARY_4K) - {1'b0, addr_lo_i}) >> BSHIFT;
        cap    = ({3'b0, room} < 16'(MAX_BURST)) ? {3'b0, room} : 16'(MAX_BURST);
        blen_o = 8'(rem_i < cap ? rem_i : cap);
    end
endmodule

// File: rtl/turfio_ddr_writer.sv
// turfio_ddr_writer: AXI4 write master that splits a stream command into 4 KB-safe INCR bursts
// and reports per-command completion with bresp / tlast error flags.
module turfio_ddr_writer
    import turfio_ddr_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 40,
    parameter int MAX_BURST  = 64,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]             cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    done,
    output logic [1:0]              done_err,
    output logic                    busy
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int OW     = $clog2(MAX_OUTSTD + 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, awaddr_q;
    logic [15:0]           rem_q;
    logic [7:0]            beats_q, awlen_q, blen;
    logic                  awvalid_q, done_q;
    logic [OW-1:0]         outstd_q, outstd_d;
    logic [1:0]            err_q, done_err_q;
    logic                  in_w, aw_fire, w_fire, b_fire, final_beat;

    ddr_burst_len #(.BYTES(BYTES), .MAX_BURST(MAX_BURST)) u_blen (
        .rem_i     (rem_q),
        .addr_lo_i (addr_q[11:0]),
        .blen_o    (blen)
    );

    always_comb begin
        in_w       = state_q == ST_WDATA;
        aw_fire    = awvalid_q && m_axi_awready;
        w_fire     = in_w && s_axis_tvalid && m_axi_wready;
        b_fire     = m_axi_bvalid;
        final_beat = rem_q == '0 && beats_q == 8'd1;
        outstd_d   = outstd_q + OW'(aw_fire) - OW'(b_fire);
    end

    // beats_q doubles as the latched burst length between awvalid assertion and the AW handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awvalid_q  <= 1'b0;
            outstd_q   <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            done_err_q <= '0;
        end else begin
            done_q   <= 1'b0;
            outstd_q <= outstd_d;
            if (b_fire && m_axi_bresp != AXI_RESP_OKAY) err_q[0] <= 1'b1;
            case (state_q)
                ST_IDLE: if (cmd_valid) begin
                    addr_q  <= cmd_addr;
                    rem_q   <= cmd_len;
                    err_q   <= '0;
                    state_q <= ST_AWREQ;
                end
                ST_AWREQ: if (!awvalid_q) begin
                    if (outstd_q < OW'(MAX_OUTSTD)) begin
                        awvalid_q <= 1'b1;
                        awaddr_q  <= addr_q;
                        awlen_q   <= blen - 8'd1;
                        beats_q   <= blen;
                    end
                end else if (m_axi_awready) begin
                    awvalid_q <= 1'b0;
                    addr_q    <= addr_q + (ADDR_WIDTH'(beats_q) << BSHIFT);
                    rem_q     <= rem_q - 16'(beats_q);
                    state_q   <= ST_WDATA;
                end
                ST_WDATA: if (w_fire) begin
                    beats_q <= beats_q - 8'd1;
                    if (s_axis_tlast != final_beat) err_q[1] <= 1'b1;
                    if (beats_q == 8'd1) state_q <= (rem_q != '0) ? ST_AWREQ : ST_WAITB;
                end
                ST_WAITB: if (outstd_q == '0) begin
                    done_q     <= 1'b1;
                    done_err_q <= err_q;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready     = state_q == ST_IDLE;
    assign busy          = state_q != ST_IDLE;
    assign s_axis_tready = in_w && m_axi_wready;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(BSHIFT);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awcache = AXI_CACHE_BUF;
    assign m_axi_awprot  = AXI_PROT_NONE;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = in_w && beats_q == 8'd1;
    assign m_axi_wvalid  = in_w && s_axis_tvalid;
    assign m_axi_bready  = 1'b1;
    assign done          = done_q;
    assign done_err      = done_err_q;
endmodule
